dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-side memory subsystem directly downstream of the CPU data port.
- Consumes the CPU's daddr/dwdata/dwe and returns drdata combinationally, in the same cycle, because the core has no stall.
- Contains word-organised data RAM with byte-lane writes, plus a small MMIO region:
  - LED/output register
  - console TX FIFO with valid/ready drain
  - optional 64-bit cycle counter

Parameters:
- DMEM_WORDS, 1024, data RAM depth in 32-bit words (power of two, 4 KB default)
- MMIO_BASE_HI, 16'h0001, value of daddr[31:16] that selects the MMIO region
- TXFIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- daddr  in  32  byte address from CPU
- dwdata  in  32  lane-replicated write data from CPU
- dwe  in  4  byte-lane write enables; dwe[i] writes dwdata[8i+7:8i]
- drdata  out  32  read data, combinational in daddr and current state
- leds  out  32  LED register contents
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts head this cycle

Behaviour:
- Decode:
  - mmio_sel = (daddr[31:16] == MMIO_BASE_HI).
  - Otherwise RAM, word index daddr[log2(DMEM_WORDS)+1:2]; upper bits ignored, so RAM aliases.
  - daddr[1:0] is ignored by this block; the CPU already steers the lanes.
- RAM:
  - Asynchronous read: drdata = mem[index].
  - On posedge, if dwe != 0 and !mmio_sel, each enabled lane is written.
  - Contents are not affected by reset.
  - Read-during-write in the same cycle returns the old word.
- MMIO map (offset daddr[3:2]; daddr[15:4] ignored):
  - 0x0 LEDS: read leds. Write: per-lane update on dwe. Reset value 0.
  - 0x4 TX:
    - Read returns {16'b0, count[7:0], 5'b0, overflow, full, empty}.
    - Write with dwe[0]: push dwdata[7:0].
    - Write with dwe[2]: clear overflow. Data value is ignored.
  - 0x8 CYCLE_LO, 0xC CYCLE_HI: read-only; see optional feature. Writes are ignored.
- TX FIFO:
  - Circular buffer with rd_ptr, wr_ptr and count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - tx_valid = (count != 0); tx_data = mem[rd_ptr]. No combinational path from the push to tx_valid.
  - Pop when tx_valid && tx_ready.
  - Push accepted when count < DEPTH, or when full and a pop occurs in the same cycle (count unchanged).
  - Push while full with no pop: byte dropped, overflow set (sticky).
  - Overflow set and clear in the same cycle: set wins.
  - Push into empty FIFO: tx_valid rises on the next cycle (one-cycle latency).
  - Pop while empty: no effect.
- Reset (asserted at any time, including mid-drain):
  - Immediately: leds=0, count=0, pointers=0, overflow=0, tx_valid=0.
  - Queued bytes are discarded.
  - On the first edge after deassertion, normal operation resumes.
- drdata in MMIO at unimplemented offsets reads 0.

Optional Feature:
- Macro DMEM_MMIO_CYCLE_CNT_EN.
- Defined:
  - 64-bit counter, reset to 0, increments by 1 every clock and wraps at 2^64-1 to 0.
  - CYCLE_LO reads bits[31:0], CYCLE_HI reads bits[63:32], both sampled at the current value (no latch).
- Undefined: no counter hardware; 0x8 and 0xC read 32'h0.

Decomposition:
- Package dmem_pkg:
  - MMIO offset constants (OFF_LEDS=2'd0, OFF_TX=2'd1, OFF_CYC_LO=2'd2, OFF_CYC_HI=2'd3)
  - TX status bit positions
  - default MMIO_BASE_HI
- Sub-module tx_fifo (parameter DEPTH):
  - Ports: clk, reset, push, push_data, pop, head, count, full, empty, overflow, ovf_clr.
  - dmem_mmio holds only decode, RAM, LED register and the counter.

Test Plan:
- RAM byte-lane write: write 0x0000_0100 dwe=4'b1111 data 0xDEADBEEF, then dwe=4'b1000 data 0x12121212 → read 0x100 returns 0x12ADBEEF. Also check alias at 0x100+4*DMEM_WORDS.
- LEDS: write 0x0001_0000 dwe=4'b0011 data 0xAAAA5555 → leds=0x00005555 and drdata matches; assert reset mid-run → leds=0 immediately.
- TX fill/overflow: tx_ready=0, push bytes 0x41..0x45 → after 4 pushes status=full, count=4. Fifth push dropped, overflow=1. Drain with tx_ready=1 → bytes 0x41,0x42,0x43,0x44 in order, then empty=1.
- Full with simultaneous push/pop: FIFO full, tx_ready=1, push 0x99 same cycle → count stays 4, 0x99 emerges last, overflow stays 0.
- Overflow clear: with overflow=1, write 0x0001_0004 dwe=4'b0100 → overflow=0. The same write with a simultaneous overflowing push → overflow stays 1.
- Cycle counter:
  - Macro defined: read CYCLE_LO at cycles N and N+10 → difference 10; preload counter to 0xFFFFFFFF_FFFFFFFF via force → wraps to 0.
  - Macro undefined: both offsets read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO subsystem: MMIO offsets,
// TX status bit layout and the default MMIO window.
package dmem_pkg;

    typedef enum logic [1:0] {
        OFF_LEDS   = 2'd0,
        OFF_TX     = 2'd1,
        OFF_CYC_LO = 2'd2,
        OFF_CYC_HI = 2'd3
    } mmio_off_e;

    localparam int unsigned TX_ST_EMPTY   = 0;
    localparam int unsigned TX_ST_FULL    = 1;
    localparam int unsigned TX_ST_OVF     = 2;
    localparam int unsigned TX_ST_CNT_LSB = 8;

    localparam logic [15:0] MMIO_BASE_HI_DEF = 16'h0001;

    // Assemble the TX status word seen at offset 0x4.
    function automatic logic [31:0] tx_status(input logic [7:0] cnt, input logic ovf,
                                              input logic full, input logic empty);
        logic [31:0] st;
        st                      = '0;
        st[TX_ST_EMPTY]         = empty;
        st[TX_ST_FULL]          = full;
        st[TX_ST_OVF]           = ovf;
        st[TX_ST_CNT_LSB +: 8]  = cnt;
        return st;
    endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Console TX FIFO: circular byte buffer with sticky overflow flag.
module tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop_ok  = pop && (r_count != '0);
    assign w_push_ok = push && ((r_count < CNT_W'(DEPTH)) || w_pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + CNT_W'(1);
            else if (!w_push_ok && w_pop_ok)
                r_count <= r_count - CNT_W'(1);
            if (push && !w_push_ok)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= push_data;
    end

    assign head     = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign overflow = r_ovf;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory: async-read byte-lane RAM plus LED / TX FIFO / cycle MMIO.
// Define DMEM_MMIO_CYCLE_CNT_EN to build the 64-bit cycle counter.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_WORDS   = 1024,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF,
    parameter int unsigned TXFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [31:0] leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned IDX_W = $clog2(DMEM_WORDS);
    localparam int unsigned CNT_W = $clog2(TXFIFO_DEPTH) + 1;

    logic [31:0]      r_mem [DMEM_WORDS];
    logic [31:0]      r_leds;
    logic             w_mmio_sel;
    logic [IDX_W-1:0] w_idx;
    mmio_off_e        w_off;
    logic             w_tx_push;
    logic             w_ovf_clr;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_mmio_sel = (daddr[31:16] == MMIO_BASE_HI);
    assign w_idx      = daddr[IDX_W+1:2];
    assign w_off      = mmio_off_e'(daddr[3:2]);
    assign w_tx_push  = w_mmio_sel && (w_off == OFF_TX) && dwe[0];
    assign w_ovf_clr  = w_mmio_sel && (w_off == OFF_TX) && dwe[2];
    assign w_unused   = &{1'b0, daddr[15:4], daddr[1:0]};

    always_ff @(posedge clk) begin
        if (!w_mmio_sel) begin
            for (int i = 0; i < 4; i++)
                if (dwe[i])
                    r_mem[w_idx][8*i +: 8] <= dwdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_leds <= '0;
        end else if (w_mmio_sel && (w_off == OFF_LEDS)) begin
            for (int i = 0; i < 4; i++)
                if (dwe[i])
                    r_leds[8*i +: 8] <= dwdata[8*i +: 8];
        end
    end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [63:0] r_cycle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cycle <= '0;
        else
            r_cycle <= r_cycle + 64'd1;
    end
`endif

    tx_fifo #(
        .DEPTH     (TXFIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_tx_push),
        .push_data (dwdata[7:0]),
        .pop       (tx_ready && !w_empty),
        .head      (tx_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty),
        .overflow  (w_ovf),
        .ovf_clr   (w_ovf_clr)
    );

    // Same-cycle read path; the core cannot stall for data.
    always_comb begin
        w_rdata = '0;
        if (!w_mmio_sel) begin
            w_rdata = r_mem[w_idx];
        end else begin
            case (w_off)
                OFF_LEDS:   w_rdata = r_leds;
                OFF_TX:     w_rdata = tx_status(8'(w_count), w_ovf, w_full, w_empty);
`ifdef DMEM_MMIO_CYCLE_CNT_EN
                OFF_CYC_LO: w_rdata = r_cycle[31:0];
                OFF_CYC_HI: w_rdata = r_cycle[63:32];
`endif
                default:    w_rdata = '0;
            endcase
        end
    end

    assign drdata   = w_rdata;
    assign leds     = r_leds;
    assign tx_valid = !w_empty;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: directed scenarios plus random traffic
// against a queue/array reference model.
module tb_dmem_mmio;

    localparam int unsigned WORDS = 1024;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] MMIO  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [3:0]  dwe = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] drdata;
    logic [31:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;

    dmem_mmio #(
        .DMEM_WORDS   (WORDS),
        .MMIO_BASE_HI (16'h0001),
        .TXFIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .leds     (leds),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit [31:0] rd;
        bit [31:0] mask;
        bit [31:0] leds;
        bit        txv;
    } item_t;

    item_t       sb[$];
    byte unsigned exp_tx[$];

    // Reference model state
    bit [31:0]    m_ram[int];
    bit [3:0]     m_val[int];
    bit [31:0]    m_leds;
    byte unsigned m_q[$];
    bit           m_ovf;
    longint unsigned tb_cyc;

    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_status();
        return {16'h0, 8'(m_q.size()), 5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    function automatic bit [31:0] m_read(input bit [31:0] a, output bit [31:0] mask);
        int idx;
        mask = '1;
        if (a[31:16] == 16'h0001) begin
            case ((a >> 2) % 4)
                0: return m_leds;
                1: return m_status();
`ifdef DMEM_MMIO_CYCLE_CNT_EN
                2: return tb_cyc[31:0];
                3: return tb_cyc[63:32];
`endif
                default: return 32'h0;
            endcase
        end
        idx = int'((a >> 2) % WORDS);
        mask = '0;
        if (!m_ram.exists(idx)) return 32'h0;
        for (int i = 0; i < 4; i++)
            mask[8*i +: 8] = {8{m_val[idx][i]}};
        return m_ram[idx];
    endfunction

    // One clock of stimulus: record what the DUT must show, then advance the model.
    task automatic cyc(input bit [31:0] a, input bit [31:0] wd, input bit [3:0] we, input bit rdy);
        item_t it;
        bit    push;
        bit    ok;
        int    idx;
        @(posedge clk);
        #1;
        daddr = a; dwdata = wd; dwe = we; tx_ready = rdy;
        it.rd   = m_read(a, it.mask);
        it.leds = m_leds;
        it.txv  = (m_q.size() != 0);
        sb.push_back(it);
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (a[31:16] == 16'h0001) begin
            case ((a >> 2) % 4)
                0: for (int i = 0; i < 4; i++)
                       if (we[i]) m_leds[8*i +: 8] = wd[8*i +: 8];
                1: begin
                    push = we[0];
                    ok   = push && (m_q.size() < DEPTH);
                    if (ok) begin
                        m_q.push_back(wd[7:0]);
                        exp_tx.push_back(wd[7:0]);
                    end
                    if (push && !ok) m_ovf = 1'b1;
                    else if (we[2])  m_ovf = 1'b0;
                end
                default: ;
            endcase
        end else begin
            idx = int'((a >> 2) % WORDS);
            if (!m_ram.exists(idx)) begin
                m_ram[idx] = '0;
                m_val[idx] = '0;
            end
            for (int i = 0; i < 4; i++)
                if (we[i]) begin
                    m_ram[idx][8*i +: 8] = wd[8*i +: 8];
                    m_val[idx][i] = 1'b1;
                end
        end
    endtask

    task automatic rd(input bit [31:0] a, input bit [31:0] exp, input string name);
        cyc(a, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check(name, drdata, exp);
    endtask

    task automatic do_reset();
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        #1;
        dwe = '0; daddr = '0; tx_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_leds", leds, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        m_leds = '0;
        m_ovf  = 1'b0;
        m_q.delete();
        exp_tx.delete();
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    // Monitor: compares every scheduled expectation and every TX handshake.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check("drdata", drdata & it.mask, it.rd & it.mask);
                check("leds", leds, it.leds);
                check("tx_valid", 32'(tx_valid), 32'(it.txv));
            end
            if (reset && tx_valid && tx_ready) begin
                if (exp_tx.size() == 0)
                    check("tx_unexpected_pop", 32'(tx_data), 32'hFFFF_FFFF);
                else
                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        bit [31:0] a;
        bit [31:0] wd;
        bit [3:0]  we;
        bit        rdy;
        int        r;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        logic [31:0] c0;
`endif
        m_leds = '0;
        m_ovf  = 1'b0;
        #12;
        check("reset_leds", leds, 32'h0);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        @(negedge clk);
        #2 reset = 1'b1;

        rd(MMIO | 32'h4, 32'h0000_0001, "status_reset");

        cyc(32'h100, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        cyc(32'h100, 32'h1212_1212, 4'b1000, 1'b0);
        rd(32'h100, 32'h12AD_BEEF, "ram_lanes");
        rd(32'h100 + 4 * WORDS, 32'h12AD_BEEF, "ram_alias");

        cyc(MMIO, 32'hAAAA_5555, 4'b0011, 1'b0);
        rd(MMIO, 32'h0000_5555, "leds_read");
        check("leds_port", leds, 32'h0000_5555);

        for (int b = 8'h41; b <= 8'h44; b++)
            cyc(MMIO | 32'h4, {4{8'(b)}}, 4'b0001, 1'b0);
        rd(MMIO | 32'h4, 32'h0000_0402, "status_full");
        cyc(MMIO | 32'h4, 32'h4545_4545, 4'b0001, 1'b0);
        rd(MMIO | 32'h4, 32'h0000_0406, "status_overflow");
        repeat (4) cyc(32'h0, 32'h0, 4'h0, 1'b1);
        rd(MMIO | 32'h4, 32'h0000_0005, "status_drained");

        cyc(MMIO | 32'h4, 32'h0, 4'b0100, 1'b0);
        rd(MMIO | 32'h4, 32'h0000_0001, "ovf_clear");
        for (int b = 8'h51; b <= 8'h54; b++)
            cyc(MMIO | 32'h4, {4{8'(b)}}, 4'b0001, 1'b0);
        cyc(MMIO | 32'h4, 32'h5555_5555, 4'b0101, 1'b0);
        rd(MMIO | 32'h4, 32'h0000_0406, "ovf_set_wins");

        cyc(MMIO | 32'h4, 32'h0, 4'b0100, 1'b0);
        cyc(MMIO | 32'h4, 32'h9999_9999, 4'b0001, 1'b1);
        rd(MMIO | 32'h4, 32'h0000_0402, "full_push_pop");
        repeat (4) cyc(32'h0, 32'h0, 4'h0, 1'b1);
        rd(MMIO | 32'h4, 32'h0000_0001, "status_empty_again");

        for (int b = 8'h61; b <= 8'h63; b++)
            cyc(MMIO | 32'h4, {4{8'(b)}}, 4'b0001, 1'b0);
        cyc(32'h0, 32'h0, 4'h0, 1'b1);
        do_reset();
        rd(MMIO | 32'h4, 32'h0000_0001, "status_after_reset");
        rd(MMIO, 32'h0, "leds_after_reset");
        rd(32'h100, 32'h12AD_BEEF, "ram_kept_over_reset");

        for (int n = 0; n < 3000; n++) begin
            r  = int'($urandom_range(0, 99));
            a  = $urandom;
            wd = $urandom;
            we = 4'($urandom_range(0, 15));
            if (((n / 200) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
            else                      rdy = ($urandom_range(0, 3) != 0);
            if (r < 35) begin
                a[11:2] = 10'($urandom_range(0, 31));
                if (a[31:16] == 16'h0001) a[31:16] = 16'h0000;
            end else begin
                a[31:16] = 16'h0001;
                if (r < 80) a[3:2] = 2'd1;
            end
            if (r >= 90) we = 4'h0;
            cyc(a, wd, we, rdy);
        end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
        cyc(MMIO | 32'h8, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        c0 = drdata;
        repeat (9) cyc(32'h0, 32'h0, 4'h0, 1'b0);
        cyc(MMIO | 32'h8, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("cycle_delta", drdata - c0, 32'd10);
        force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_cycle;
        daddr = MMIO | 32'hC;
        @(negedge clk);
        check("cycle_hi_max", drdata, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cycle_hi_wrap", drdata, 32'h0);
        daddr = MMIO | 32'h8;
        #1;
        check("cycle_lo_wrap", drdata, 32'h0);
`else
        rd(MMIO | 32'h8, 32'h0, "cycle_lo_absent");
        rd(MMIO | 32'hC, 32'h0, "cycle_hi_absent");
`endif

        for (int k = 0; k < 50 && m_q.size() > 0; k++)
            cyc(32'h0, 32'h0, 4'h0, 1'b1);
        cyc(32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        #1;
        check("drain_all_seen", 32'(exp_tx.size()), 32'h0);
        check("tx_valid_end", 32'(tx_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
